// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: sequencer FSM states, the
// tracking-pipe tag, and a helper that normalises the chunk count.
package conv_pkg;

    // Sequencer phases: accept first beat, accept remaining beats,
    // wait for tree results to drain, present the group sum.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    // Tag travelling alongside a chunk while it is inside the adder tree.
    typedef struct packed {
        logic valid;
        logic last;
    } seq_tag_t;

    // Effective chunk count: zero means one chunk, anything above the
    // maximum is clamped to the maximum.
    function automatic int unsigned eff_chunks(input int unsigned cfg,
                                               input int unsigned max_chunks);
        if (cfg == 0) begin
            return 1;
        end
        if (cfg > max_chunks) begin
            return max_chunks;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/accum_sat.sv
// Next-value logic for the group accumulator: clear, hold, or add one tree
// result. Build option: define ADDER_TREE_SEQ_SAT_EN for a signed
// saturating add; otherwise the add wraps modulo 2^WIDTH.
module accum_sat #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_q,
    input  logic [WIDTH-1:0] addend,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] acc_d
);

    logic [WIDTH-1:0] sum;

    // Raw two's-complement sum, optionally clamped on signed overflow.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the value just computed, exactly like wires evaluated in order.
        sum = acc_q + addend;
`ifdef ADDER_TREE_SEQ_SAT_EN
        // Overflow only when both operands share a sign and the result flips it.
        if ((acc_q[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1])) begin
            sum = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Select between clear (start of group), add (tree result exits) and hold.
    always_comb begin
        // NOTE: assign a default before any if/case so every path drives acc_d;
        // a missing branch would otherwise infer a latch.
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

endmodule

// File: rtl/adder_tree.sv
// Pipelined binary adder tree: INPUT_NUM lanes reduced to one sum through
// $clog2(INPUT_NUM) register stages. INPUT_NUM must be a power of two.
// Sums wrap modulo 2^WIDTH; overflow is not flagged.
module adder_tree #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8
) (
    input  logic                                clk,
    input  logic [INPUT_NUM-1:0][WIDTH-1:0]     indata,
    output logic [WIDTH-1:0]                    res
);

    localparam int NODES = 2 * INPUT_NUM - 1;

    // Heap layout: node 0 is the root, node j has children 2j+1 and 2j+2,
    // leaves occupy the last INPUT_NUM slots and are the raw inputs.
    logic [WIDTH-1:0] sum_q [INPUT_NUM-1];
    logic [WIDTH-1:0] node  [NODES];

    // Gather registered internal nodes and live leaf inputs into one array.
    always_comb begin
        for (int j = 0; j < INPUT_NUM - 1; j++) begin
            node[j] = sum_q[j];
        end
        for (int i = 0; i < INPUT_NUM; i++) begin
            node[INPUT_NUM - 1 + i] = indata[i];
        end
    end

    // Every internal node registers the sum of its two children.
    // NOTE: pure datapath registers carry no reset; whoever consumes res
    // tracks validity separately, so power-up contents are never used.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking '<=' so all nodes update from
        // the previous cycle's values, giving a true one-stage-per-level pipe.
        for (int j = 0; j < INPUT_NUM - 1; j++) begin
            sum_q[j] <= node[2*j + 1] + node[2*j + 2];
        end
    end

    assign res = sum_q[0];

endmodule

// File: rtl/adder_tree_seq.sv
// Sequencer/accumulator in front of a pipelined adder_tree. Feeds one chunk
// per cycle into the tree, tracks chunks in flight with a tag pipe matching
// the tree latency, accumulates the tree results and hands one sum per group
// downstream over valid/ready. Build option: ADDER_TREE_SEQ_SAT_EN selects a
// saturating accumulator (see accum_sat).
module adder_tree_seq
    import conv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int TREE_LAT  = $clog2(INPUT_NUM),
    parameter int CHUNK_MAX = 16,
    parameter int CNT_W     = $clog2(CHUNK_MAX + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CNT_W-1:0]                 cfg_chunks,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INPUT_NUM-1:0][WIDTH-1:0]  in_data,
    output logic [INPUT_NUM-1:0][WIDTH-1:0]  tree_data,
    input  logic [WIDTH-1:0]                 tree_res,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             busy
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] n_chunks_q, n_chunks_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] cfg_eff;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    seq_tag_t         pipe_q [TREE_LAT];
    seq_tag_t         pipe_d [TREE_LAT];
    seq_tag_t         tag_in;
    seq_tag_t         tag_out;
    logic             beat;
    logic             acc_clr;

    // An accepted beat; in_ready is a register so this has no loop through it.
    assign beat    = in_valid & in_ready_q;
    assign cfg_eff = CNT_W'(eff_chunks(32'(cfg_chunks), CHUNK_MAX));
    assign tag_out = pipe_q[TREE_LAT-1];

    // FSM next state, chunk counting and accumulator clear on the first beat.
    always_comb begin
        state_d    = state_q;
        n_chunks_d = n_chunks_q;
        beat_cnt_d = beat_cnt_q;
        acc_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    n_chunks_d = cfg_eff;
                    beat_cnt_d = CNT_W'(1);
                    acc_clr    = 1'b1;
                    state_d    = (cfg_eff == CNT_W'(1)) ? DRAIN : FEED;
                end
            end
            FEED: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_d == n_chunks_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last chunk's sum is folded in as its tag exits.
                if (tag_out.valid && tag_out.last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag pipe shifts every cycle so tag position mirrors tree stage position.
    always_comb begin
        tag_in.valid = beat;
        tag_in.last  = beat && (beat_cnt_d == n_chunks_d);
        pipe_d[0]    = tag_in;
        for (int i = 1; i < TREE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Handshake outputs are registered from the next state.
    always_comb begin
        in_ready_d  = (state_d == IDLE) || (state_d == FEED);
        out_valid_d = (state_d == OUT);
    end

    accum_sat #(
        .WIDTH (WIDTH)
    ) u_accum (
        .acc_q  (acc_q),
        .addend (tree_res),
        .en     (tag_out.valid),
        .clr    (acc_clr),
        .acc_d  (acc_d)
    );

    // All sequencer state; reset aborts any group and discards in-flight tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            n_chunks_q  <= '0;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TREE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_chunks_q  <= n_chunks_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < TREE_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Tree input is forced to zero outside accepted beats.
    always_comb begin
        tree_data = beat ? in_data : '0;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? acc_q : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_tree_seq.sv
// Bench for adder_tree_seq with a real adder_tree attached. Stimulus pushes
// expected group sums into a queue; a monitor pops and compares on every
// output handshake and checks stability while out_ready is held low.
module tb_adder_tree_seq;

    localparam int WIDTH     = 32;
    localparam int INPUT_NUM = 8;
    localparam int TREE_LAT  = 3;
    localparam int CHUNK_MAX = 16;
    localparam int CNT_W     = 5;

    logic                             clk;
    logic                             rst;
    logic [CNT_W-1:0]                 cfg_chunks;
    logic                             in_valid;
    logic                             in_ready;
    logic [INPUT_NUM-1:0][WIDTH-1:0]  in_data;
    logic [INPUT_NUM-1:0][WIDTH-1:0]  tree_data;
    logic [WIDTH-1:0]                 tree_res;
    logic                             out_valid;
    logic                             out_ready;
    logic [WIDTH-1:0]                 out_data;
    logic                             busy;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] sb [$];
    logic             stalled   = 1'b0;
    logic [WIDTH-1:0] stall_val = '0;

`ifdef ADDER_TREE_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [WIDTH-1:0] OVF_EXP = 32'h8000_0010;
`endif

    adder_tree_seq #(
        .WIDTH     (WIDTH),
        .INPUT_NUM (INPUT_NUM),
        .TREE_LAT  (TREE_LAT),
        .CHUNK_MAX (CHUNK_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_chunks (cfg_chunks),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tree_data  (tree_data),
        .tree_res   (tree_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    adder_tree #(
        .WIDTH     (WIDTH),
        .INPUT_NUM (INPUT_NUM)
    ) u_tree (
        .clk    (clk),
        .indata (tree_data),
        .res    (tree_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [INPUT_NUM-1:0][WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
        logic [INPUT_NUM-1:0][WIDTH-1:0] r;
        for (int i = 0; i < INPUT_NUM; i++) begin
            r[i] = v;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one chunk and hold it until accepted (bounded).
    task automatic send_beat(input logic [INPUT_NUM-1:0][WIDTH-1:0] v);
        int k = 0;
        in_valid = 1'b1;
        in_data  = v;
        #0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("send_in_ready", {31'd0, in_ready}, 32'd1);
        check("tree_pass", tree_data[0], v[0]);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_out_valid();
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || out_valid) && k < 50) begin
            tick();
            k++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: compare on each handshake, check stability during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, stall_val);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%08h expected none", out_data);
                end else begin
                    check("sum", out_data, sb.pop_front());
                end
                stalled <= 1'b0;
            end else if (out_valid) begin
                stalled   <= 1'b1;
                stall_val <= out_data;
            end else begin
                stalled <= 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cfg_chunks = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        #1;
        rst = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tree_data", tree_data[0] | tree_data[7], 32'd0);
        rst = 1'b1;
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_busy", {31'd0, busy}, 32'd0);

        // Single chunk, exact latency
        cfg_chunks = 5'd1;
        sb.push_back(32'd256);
        send_beat(fill(32'd32));
        check("single_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("lat_pre", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_4", {31'd0, out_valid}, 32'd1);
        check("lat_data", out_data, 32'd256);
        wait_idle();

        // cfg_chunks = 0 behaves as one chunk
        cfg_chunks = 5'd0;
        sb.push_back(32'd256);
        send_beat(fill(32'd32));
        wait_idle();

        // Back-to-back 4 chunks
        cfg_chunks = 5'd4;
        sb.push_back(32'd80);
        for (int c = 1; c <= 4; c++) begin
            send_beat(fill(c));
        end
        check("b2b_in_ready", {31'd0, in_ready}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Bubbles plus backpressure, next group held off until handshake
        cfg_chunks = 5'd3;
        out_ready  = 1'b0;
        sb.push_back(32'd120);
        for (int c = 0; c < 3; c++) begin
            send_beat(fill(32'd5));
            if (c < 2) begin
                repeat (2) tick();
            end
        end
        wait_out_valid();
        cfg_chunks = 5'd1;
        in_valid   = 1'b1;
        in_data    = fill(32'd7);
        sb.push_back(32'd56);
        for (int s = 0; s < 5; s++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_data", out_data, 32'd120);
            check("bp_tree_zero", tree_data[3], 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("hs_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        wait_idle();

        // Overflow across two chunks
        cfg_chunks = 5'd2;
        sb.push_back(OVF_EXP);
        send_beat({{(INPUT_NUM-1){32'd0}}, 32'h7FFF_FFF0});
        send_beat({{(INPUT_NUM-1){32'd0}}, 32'h0000_0020});
        wait_idle();

        // Idle with garbage on in_data
        in_data = fill(32'hDEAD_BEEF);
        for (int s = 0; s < 10; s++) begin
            tick();
            check("idle_tree", tree_data[s % INPUT_NUM], 32'd0);
            check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        end
        in_data = '0;

        // Reset in the middle of DRAIN
        cfg_chunks = 5'd2;
        send_beat(fill(32'd9));
        send_beat(fill(32'd9));
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        cfg_chunks = 5'd1;
        sb.push_back(32'd24);
        send_beat(fill(32'd3));
        wait_idle();

        repeat (5) tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
